// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential packed-BCD to binary converter (reverse double-dabble)
// Optional invalid-digit check: define BCD2BIN_ERRCHK_EN.
module bcd_to_bin #(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bin_out,
   output logic                  err
);

   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state_q;
   logic [2*W-1:0]  sr_q;
   logic [2*W-1:0]  sr_d;
   logic [CW-1:0]   cnt_q;
   logic            busy_q;
   logic            done_q;
   logic [W-1:0]    bin_out_q;
   logic            err_q;

`ifdef BCD2BIN_ERRCHK_EN
   logic            err_flag_q;
   logic            bad_digit;

   // Flag any operand nibble above 9 so it can be latched on the accepting edge
   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9) begin
            bad_digit = 1'b1;
         end
      end
   end
`endif

   // One reverse double-dabble step: shift right, then pull 3 out of every BCD nibble >= 8
   always_comb begin
      logic [3:0] nib;
      nib  = '0;
      sr_d = {1'b0, sr_q[2*W-1:1]};
      for (int i = 0; i < DIGITS; i++) begin
         nib = sr_d[W + 4*i +: 4];
         if (nib >= 4'd8) begin
            sr_d[W + 4*i +: 4] = nib - 4'd3;
         end
      end
   end

   // Control FSM with registered outputs; the DONE state publishes the result and returns to IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         sr_q       <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         bin_out_q  <= '0;
         err_q      <= 1'b0;
`ifdef BCD2BIN_ERRCHK_EN
         err_flag_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  sr_q    <= {bcd_in, {W{1'b0}}};
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
`ifdef BCD2BIN_ERRCHK_EN
                  err_flag_q <= bad_digit;
`endif
               end
            end
            S_RUN: begin
               sr_q  <= sr_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(W - 1)) begin
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               bin_out_q <= sr_q[W-1:0];
               done_q    <= 1'b1;
               busy_q    <= 1'b0;
               state_q   <= S_IDLE;
`ifdef BCD2BIN_ERRCHK_EN
               err_q     <= err_flag_q;
`else
               err_q     <= 1'b0;
`endif
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign bin_out = bin_out_q;
   assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - randomized self-checking bench for bcd_to_bin against a decimal model
module tb_bcd_to_bin;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  bcd_in;
   logic        busy;
   logic        done;
   logic [7:0]  bin_out;
   logic        err;

   logic        start3;
   logic [11:0] bcd3;
   logic        busy3;
   logic        done3;
   logic [11:0] bin3;
   logic        err3;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bcd_to_bin #(.DIGITS(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .bcd_in  (bcd_in),
      .busy    (busy),
      .done    (done),
      .bin_out (bin_out),
      .err     (err)
   );

   bcd_to_bin #(.DIGITS(3)) dut3 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start3),
      .bcd_in  (bcd3),
      .busy    (busy3),
      .done    (done3),
      .bin_out (bin3),
      .err     (err3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Decimal value of a packed BCD word: sum of digit_i * 10^i
   function automatic int ref_dec(input logic [31:0] b, input int nd);
      int v;
      int p;
      v = 0;
      p = 1;
      for (int i = 0; i < nd; i++) begin
         v += int'(b[4*i +: 4]) * p;
         p *= 10;
      end
      return v;
   endfunction

   // Called #1 after a rising edge with the DUT idle; returns edges from accept to done
   task automatic run_conv(input logic [7:0] v, output int lat, output int busy_cyc);
      bcd_in = v;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      bcd_in   = 8'($urandom);
      lat      = 0;
      busy_cyc = busy ? 1 : 0;
      while (lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) break;
         if (busy) busy_cyc++;
      end
      if (!done) check("conv_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int lat;
      int bc;
      int ndone;
      logic [7:0] v;
      logic [7:0] exp_last;

      rst_n  = 1'b0;
      start  = 1'b0;
      bcd_in = 8'h00;
      start3 = 1'b0;
      bcd3   = 12'h000;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_bin", 32'(bin_out), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_conv(8'h99, lat, bc);
      check("h99_lat", 32'(lat), 32'd9);
      check("h99_busy", 32'(bc), 32'd9);
      check("h99_bin", 32'(bin_out), 32'(ref_dec(32'h99, 2)));
      check("h99_err", 32'(err), 32'd0);

      run_conv(8'h00, lat, bc);
      check("h00_lat", 32'(lat), 32'd9);
      check("h00_bin", 32'(bin_out), 32'd0);
      run_conv(8'h47, lat, bc);
      check("h47_bin", 32'(bin_out), 32'h2F);

      for (int t = 0; t < 10; t++) begin
         for (int o = 0; o < 10; o++) begin
            v = {4'(t), 4'(o)};
            run_conv(v, lat, bc);
            check("sweep_bin", 32'(bin_out), 32'(ref_dec(32'(v), 2)));
            check("sweep_lat", 32'(lat), 32'd9);
         end
      end

      for (int r = 0; r < 40; r++) begin
         v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         run_conv(v, lat, bc);
         check("rand_bin", 32'(bin_out), 32'(ref_dec(32'(v), 2)));
         check("rand_err", 32'(err), 32'd0);
         exp_last = 8'(ref_dec(32'(v), 2));
      end

      repeat (3) @(posedge clk);
      #1;
      check("hold_bin", 32'(bin_out), 32'(exp_last));
      check("hold_done", 32'(done), 32'd0);

      // start held high across the whole conversion, operand changed mid-run
      bcd_in = 8'h58;
      start  = 1'b1;
      @(posedge clk);
      #1;
      bcd_in = 8'h31;
      ndone  = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            ndone++;
            check("held_bin", 32'(bin_out), 32'(ref_dec(32'h58, 2)));
         end
         if (i == 9)  check("held_busy_low", 32'(busy), 32'd0);
         if (i == 10) check("held_reaccept", 32'(busy), 32'd1);
      end
      check("held_ndone", 32'(ndone), 32'd1);
      start = 1'b0;
      lat   = 0;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("second_lat", 32'(lat), 32'd9);
      check("second_bin", 32'(bin_out), 32'(ref_dec(32'h31, 2)));

      // reset in the middle of RUN
      @(posedge clk);
      #1;
      bcd_in = 8'h37;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_bin", 32'(bin_out), 32'd0);
      check("abort_err", 32'(err), 32'd0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
         if (i == 2) rst_n = 1'b1;
      end
      check("abort_nodone", 32'(ndone), 32'd0);
      run_conv(8'h25, lat, bc);
      check("after_abort_bin", 32'(bin_out), 32'h19);
      check("after_abort_lat", 32'(lat), 32'd9);

`ifdef BCD2BIN_ERRCHK_EN
      run_conv(8'h5A, lat, bc);
      check("bad_err", 32'(err), 32'd1);
      run_conv(8'h12, lat, bc);
      check("good_err", 32'(err), 32'd0);
      check("good_bin", 32'(bin_out), 32'h0C);
`else
      run_conv(8'h5A, lat, bc);
      check("bad_err_off", 32'(err), 32'd0);
      run_conv(8'h12, lat, bc);
      check("good_err", 32'(err), 32'd0);
      check("good_bin", 32'(bin_out), 32'h0C);
`endif

      // three-digit instance
      bcd3   = 12'h999;
      start3 = 1'b1;
      @(posedge clk);
      #1;
      start3 = 1'b0;
      bcd3   = 12'h000;
      lat    = 0;
      while (!done3 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("d3_lat", 32'(lat), 32'd13);
      check("d3_bin", 32'(bin3), 32'(ref_dec(32'h999, 3)));
      check("d3_err", 32'(err3), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
